// File: rtl/cpu_reset_sequencer.sv
// CPU reset sequencer: holds the CPU in reset until the selected clock has been
// stably locked for HOLD_CYCLES, and re-sequences on lock loss, source switch or software request.
module cpu_reset_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16
) (
    input  logic       clk_cpu,
    input  logic       reset,
    input  logic       locked,
    input  logic       clk_wiz_enable,
    input  logic       sw_reset_req,
    input  logic       lock_lost_clr,
    output logic       cpu_reset_n,
    output logic [1:0] seq_state,
    output logic [7:0] lock_loss_count,
    output logic       lock_lost
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'b00,
        ST_COUNT     = 2'b01,
        ST_RUN       = 2'b10,
        ST_ILLEGAL   = 2'b11
    } state_e;

    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] locked_sync_q, locked_sync_d;
    logic [SYNC_STAGES-1:0] sel_sync_q, sel_sync_d;
    logic                   sel_q, sel_d;
    state_e                 state_q, state_d;
    logic [15:0]            cnt_q, cnt_d;
    logic                   cpu_reset_n_q, cpu_reset_n_d;
    logic [7:0]             loss_cnt_q, loss_cnt_d;
    logic                   lock_lost_q, lock_lost_d;

    logic locked_s;
    logic sel_s;
    logic sel_chg;
    logic loss_evt;

    assign locked_s = locked_sync_q[SYNC_STAGES-1];
    assign sel_s    = sel_sync_q[SYNC_STAGES-1];
    assign sel_chg  = sel_s ^ sel_q;

    always_comb begin
        locked_sync_d = {locked_sync_q[SYNC_STAGES-2:0], locked};
        sel_sync_d    = {sel_sync_q[SYNC_STAGES-2:0], clk_wiz_enable};
        sel_d         = sel_s;
        state_d       = state_q;
        cnt_d         = cnt_q;
        loss_evt      = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s && !sel_chg) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                cnt_d = cnt_q + 16'd1;
                if (!locked_s || sel_chg) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (sw_reset_req) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_d  = ST_WAIT_LOCK;
                    cnt_d    = '0;
                    loss_evt = 1'b1;
                end else if (sel_chg) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (sw_reset_req) begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        // Reset output tracks the next state so it moves on the same edge as the FSM.
        cpu_reset_n_d = (state_d == ST_RUN);

        loss_cnt_d = loss_cnt_q;
        if (loss_evt && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end

        // A loss in the same cycle as a clear must stay visible.
        lock_lost_d = lock_lost_q;
        if (loss_evt) begin
            lock_lost_d = 1'b1;
        end else if (lock_lost_clr) begin
            lock_lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            locked_sync_q <= '0;
            sel_sync_q    <= '0;
            sel_q         <= 1'b0;
            state_q       <= ST_WAIT_LOCK;
            cnt_q         <= '0;
            cpu_reset_n_q <= 1'b0;
            loss_cnt_q    <= '0;
            lock_lost_q   <= 1'b0;
        end else begin
            locked_sync_q <= locked_sync_d;
            sel_sync_q    <= sel_sync_d;
            sel_q         <= sel_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cpu_reset_n_q <= cpu_reset_n_d;
            loss_cnt_q    <= loss_cnt_d;
            lock_lost_q   <= lock_lost_d;
        end
    end

    assign cpu_reset_n     = cpu_reset_n_q;
    assign seq_state       = state_q;
    assign lock_loss_count = loss_cnt_q;
    assign lock_lost       = lock_lost_q;

endmodule

// File: tb/tb_cpu_reset_sequencer.sv
// Bench for cpu_reset_sequencer: cpu_reset_n transitions are predicted into a queue
// when stimulus is applied and matched against the DUT edge by edge.
module tb_cpu_reset_sequencer;

    localparam int S = 2;
    localparam int H = 16;

    logic       clk_cpu;
    logic       reset;
    logic       locked;
    logic       clk_wiz_enable;
    logic       sw_reset_req;
    logic       lock_lost_clr;
    logic       cpu_reset_n;
    logic [1:0] seq_state;
    logic [7:0] lock_loss_count;
    logic       lock_lost;

    cpu_reset_sequencer #(.SYNC_STAGES(S), .HOLD_CYCLES(H)) dut (
        .clk_cpu        (clk_cpu),
        .reset          (reset),
        .locked         (locked),
        .clk_wiz_enable (clk_wiz_enable),
        .sw_reset_req   (sw_reset_req),
        .lock_lost_clr  (lock_lost_clr),
        .cpu_reset_n    (cpu_reset_n),
        .seq_state      (seq_state),
        .lock_loss_count(lock_loss_count),
        .lock_lost      (lock_lost)
    );

    typedef struct {
        int unsigned edge_no;
        logic        val;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int unsigned edge_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        mon_en = 1'b0;
    logic        rn_prev = 1'b0;
    int unsigned n, n2;

    initial begin
        clk_cpu = 1'b0;
        forever #5 clk_cpu = ~clk_cpu;
    end

    always @(posedge clk_cpu) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push(input int unsigned e, input logic v);
        exp_t t;
        t.edge_no = e;
        t.val     = v;
        exp_q.push_back(t);
    endtask

    task automatic wait_n(input int k);
        repeat (k) @(negedge clk_cpu);
    endtask

    // Every observed cpu_reset_n transition must match the oldest prediction.
    always @(negedge clk_cpu) begin
        if (mon_en && (cpu_reset_n !== rn_prev)) begin
            if (exp_q.size() == 0) begin
                chk("rn_unexpected", {31'd0, cpu_reset_n}, {31'd0, rn_prev});
            end else begin
                mon_e = exp_q.pop_front();
                chk("rn_edge", edge_cnt, mon_e.edge_no);
                chk("rn_val", {31'd0, cpu_reset_n}, {31'd0, mon_e.val});
            end
        end
        rn_prev <= cpu_reset_n;
    end

    initial begin
        reset = 1'b1; locked = 1'b0; clk_wiz_enable = 1'b0;
        sw_reset_req = 1'b0; lock_lost_clr = 1'b0;
        wait_n(3);
        chk("rst_rn", {31'd0, cpu_reset_n}, 0);
        chk("rst_state", {30'd0, seq_state}, 0);
        chk("rst_cnt", {24'd0, lock_loss_count}, 0);
        chk("rst_lost", {31'd0, lock_lost}, 0);
        reset = 1'b0;
        mon_en = 1'b1;
        wait_n(2);
        chk("post_rst_state", {30'd0, seq_state}, 0);

        // Power-up sequencing
        n = edge_cnt; locked = 1'b1;
        push(n + 1 + S + H, 1'b1);
        wait_n(S);
        chk("pu_wait", {30'd0, seq_state}, 0);
        wait_n(1);
        chk("pu_count", {30'd0, seq_state}, 1);
        wait_n(H - 1);
        chk("pu_count_end", {30'd0, seq_state}, 1);
        chk("pu_rn_low", {31'd0, cpu_reset_n}, 0);
        wait_n(1);
        chk("pu_run", {30'd0, seq_state}, 2);
        chk("pu_rn_high", {31'd0, cpu_reset_n}, 1);

        // Lock loss for 5 cycles
        n = edge_cnt; locked = 1'b0;
        push(n + 1 + S, 1'b0);
        wait_n(5);
        n2 = edge_cnt; locked = 1'b1;
        push(n2 + 1 + S + H, 1'b1);
        wait_n(1);
        chk("ll_count", {24'd0, lock_loss_count}, 1);
        chk("ll_flag", {31'd0, lock_lost}, 1);
        wait_n(S + H + 2);
        chk("ll_run", {30'd0, seq_state}, 2);

        // Clock source switch with lock held
        n = edge_cnt; clk_wiz_enable = 1'b1;
        push(n + 1 + S, 1'b0);
        push(n + 2 + S + H, 1'b1);
        wait_n(S + H + 4);
        chk("sw_src_cnt", {24'd0, lock_loss_count}, 1);
        chk("sw_src_run", {30'd0, seq_state}, 2);

        // Software reset in RUN
        n = edge_cnt; sw_reset_req = 1'b1;
        push(n + 1, 1'b0);
        push(n + 1 + H, 1'b1);
        wait_n(1); sw_reset_req = 1'b0;
        chk("swr_count", {30'd0, seq_state}, 1);
        wait_n(H + 2);
        chk("swr_run", {30'd0, seq_state}, 2);

        // Software reset at counter = 10 restarts the hold count
        n = edge_cnt; locked = 1'b0;
        push(n + 1 + S, 1'b0);
        wait_n(3);
        n2 = edge_cnt; locked = 1'b1;
        wait_n(S + 11);
        sw_reset_req = 1'b1;
        push(n2 + S + 12 + H, 1'b1);
        wait_n(1); sw_reset_req = 1'b0;
        chk("swc_count", {30'd0, seq_state}, 1);
        wait_n(H + 2);
        chk("swc_run", {30'd0, seq_state}, 2);
        chk("swc_losses", {24'd0, lock_loss_count}, 2);

        // Sticky flag: clear alone, then clear colliding with a loss
        lock_lost_clr = 1'b1; wait_n(1); lock_lost_clr = 1'b0;
        chk("clr_alone1", {31'd0, lock_lost}, 0);
        n = edge_cnt; locked = 1'b0;
        push(n + 1 + S, 1'b0);
        wait_n(S);
        lock_lost_clr = 1'b1; wait_n(1); lock_lost_clr = 1'b0;
        chk("clr_vs_set", {31'd0, lock_lost}, 1);
        chk("clr_vs_set_cnt", {24'd0, lock_loss_count}, 3);
        wait_n(1);
        n2 = edge_cnt; locked = 1'b1;
        push(n2 + 1 + S + H, 1'b1);
        wait_n(S + H + 2);
        lock_lost_clr = 1'b1; wait_n(1); lock_lost_clr = 1'b0;
        chk("clr_alone2", {31'd0, lock_lost}, 0);

        // Saturation: 257 more losses for 260 total
        for (int i = 0; i < 257; i++) begin
            n = edge_cnt; locked = 1'b0;
            push(n + 1 + S, 1'b0);
            wait_n(3);
            n2 = edge_cnt; locked = 1'b1;
            push(n2 + 1 + S + H, 1'b1);
            wait_n(S + H + 1);
        end
        chk("sat_cnt", {24'd0, lock_loss_count}, 255);
        chk("sat_flag", {31'd0, lock_lost}, 1);
        chk("sat_run", {30'd0, seq_state}, 2);

        // Async reset in RUN, no clock edge in between
        #2 mon_en = 1'b0; reset = 1'b1; clk_wiz_enable = 1'b0;
        #1;
        chk("arun_rn", {31'd0, cpu_reset_n}, 0);
        chk("arun_state", {30'd0, seq_state}, 0);
        chk("arun_cnt", {24'd0, lock_loss_count}, 0);
        chk("arun_flag", {31'd0, lock_lost}, 0);
        wait_n(2);
        reset = 1'b0; n = edge_cnt;
        wait_n(S + 8);
        chk("acnt_pre", {30'd0, seq_state}, 1);

        // Async reset mid-COUNT (counter = 7)
        #2 mon_en = 1'b0; reset = 1'b1;
        #1;
        chk("acnt_rn", {31'd0, cpu_reset_n}, 0);
        chk("acnt_state", {30'd0, seq_state}, 0);
        chk("acnt_cnt", {24'd0, lock_loss_count}, 0);
        chk("acnt_flag", {31'd0, lock_lost}, 0);
        wait_n(1);
        reset = 1'b0; n = edge_cnt;
        push(n + 1 + S + H, 1'b1);
        mon_en = 1'b1;
        wait_n(S + H + 2);
        chk("final_run", {30'd0, seq_state}, 2);
        chk("final_rn", {31'd0, cpu_reset_n}, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_reset_sequencer.md
CPU_RESET_SEQUENCER -- requirements
Module: cpu_reset_sequencer

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for locked and clk_wiz_enable (legal 2..4).
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 16, meaning clk_cpu cycles of stable lock before reset release (legal 1..65535).
REQ-003 The module SHALL have port clk_cpu, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port locked, input, 1 bit: lock indication from the clock select, asynchronous to clk_cpu, active high.
REQ-006 The module SHALL have port clk_wiz_enable, input, 1 bit: clock source select level, asynchronous; any change forces re-sequencing.
REQ-007 The module SHALL have port sw_reset_req, input, 1 bit: synchronous single-cycle software reset request.
REQ-008 The module SHALL have port lock_lost_clr, input, 1 bit: synchronous clear of the lock_lost flag.
REQ-009 The module SHALL have port cpu_reset_n, output, 1 bit: registered active-low CPU reset.
REQ-010 The module SHALL have port seq_state, output, 2 bits: current state, with 00 = WAIT_LOCK, 01 = COUNT, 10 = RUN (11 unused).
REQ-011 The module SHALL have port lock_loss_count, output, 8 bits: saturating count of lock losses seen in RUN.
REQ-012 The module SHALL have port lock_lost, output, 1 bit: sticky flag, set on any lock loss in RUN.

Function
REQ-013 locked and clk_wiz_enable SHALL each pass through a SYNC_STAGES flop chain; sync outputs are locked_s and sel_s.
REQ-014 A registered copy sel_q of sel_s SHALL exist; sel_chg = sel_s XOR sel_q.
REQ-015 A 16-bit hold counter SHALL be cleared on every entry to COUNT.
REQ-016 WAIT_LOCK SHALL go to COUNT when locked_s = 1 and sel_chg = 0; sw_reset_req is ignored in this state.
REQ-017 COUNT SHALL increment the counter each cycle.
- locked_s = 0 or sel_chg = 1 -> WAIT_LOCK.
- Else sw_reset_req = 1 -> counter restarts at 0, stays in COUNT.
- Else counter == HOLD_CYCLES-1 -> RUN.
REQ-018 RUN SHALL apply its exits in this priority order:
- locked_s = 0 -> WAIT_LOCK (a lock loss).
- Else sel_chg = 1 -> WAIT_LOCK.
- Else sw_reset_req = 1 -> COUNT.
REQ-019 cpu_reset_n SHALL be a flop loaded with (next_state == RUN), so it rises on the same edge as the state enters RUN and falls on the same edge as the state leaves RUN.
REQ-020 Reset release latency SHALL be exact: with locked high before sampling edge E0 and no other events, cpu_reset_n goes 1 after edge E0+SYNC_STAGES+HOLD_CYCLES (18 edges with defaults).
REQ-021 Lock-loss latency SHALL be exact: locked falling before edge E0 in RUN -> cpu_reset_n goes 0 after edge E0+SYNC_STAGES.
REQ-022 On each lock loss in RUN, lock_loss_count SHALL increment, holding at 255 when full; a sel_chg exit or a software exit does not count.
REQ-023 On each lock loss in RUN, lock_lost SHALL set; lock_lost_clr clears it; set and clear in the same cycle -> set wins.
REQ-024 A locked glitch shorter than one clk_cpu period MAY be missed, and SHALL NOT produce X or an illegal state.
REQ-025 seq_state = 11 SHALL never occur; if reached, the next edge SHALL go to WAIT_LOCK with cpu_reset_n = 0.

Reset
REQ-026 reset = 1 SHALL asynchronously force the following, regardless of clk_cpu:
- state WAIT_LOCK, counter 0;
- all sync flops and sel_q 0;
- cpu_reset_n 0, lock_loss_count 0, lock_lost 0.
REQ-027 Reset asserted mid-COUNT or in RUN SHALL drop cpu_reset_n to 0 immediately, without waiting for a clock edge.
REQ-028 After reset deasserts, full sequencing per REQ-020 SHALL be required before cpu_reset_n rises.
REQ-029 No output SHALL change on the first edge after reset deassertion except through normal state transitions.

Verification
REQ-030 Power-up: reset pulse, then locked = 1, clk_wiz_enable = 0 -> cpu_reset_n = 0 for 17 edges, 1 after edge 18; seq_state goes 00, 01, 10.
REQ-031 Lock loss: in RUN drop locked for 5 cycles -> cpu_reset_n = 0 after 2 edges, lock_loss_count = 1, lock_lost = 1; on relock, release 18 edges later.
REQ-032 Source switch: in RUN toggle clk_wiz_enable with locked held 1 -> cpu_reset_n falls 3 edges later (2 sync edges + 1 detect edge), then rises 16+ edges after re-entering COUNT; lock_loss_count unchanged.
REQ-033 Software reset: sw_reset_req in RUN -> cpu_reset_n = 0 next edge, 1 after 16 more edges; sw_reset_req at counter = 10 in COUNT restarts the count at 0.
REQ-034 Saturation and sticky flag:
- 260 lock losses -> lock_loss_count = 255.
- lock_lost_clr in the same cycle as a loss -> lock_lost = 1.
- lock_lost_clr alone -> lock_lost = 0.
REQ-035 Async reset mid-COUNT (counter = 7) -> all outputs at reset values within the reset pulse, with no clock edge applied.
